// File: rtl/ift_sram_pkg.sv
// Shared types and helpers for the multi-port IFT SRAM model.
// Scrub FSM states, size limits and the byte-enable expander.
package ift_sram_pkg;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    localparam int MAX_PORTS  = 4;
    localparam int MAX_RD_LAT = 3;
    localparam int MAX_BYTES  = 32;

    function automatic logic [8*MAX_BYTES-1:0] be_to_mask(
        input logic [MAX_BYTES-1:0] be
    );
        logic [8*MAX_BYTES-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ift_sram_rd_pipe.sv
// Per-port read return pipeline: RD_LAT stages of valid/err/data/taint.
// Data lanes only advance with valid, so the last result is held.
module ift_sram_rd_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] in_taint,
    output logic                  out_valid,
    output logic                  out_err,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] out_taint
);

    logic [RD_LAT-1:0]                 v;
    logic [RD_LAT-1:0]                 e;
    logic [RD_LAT-1:0][DATA_WIDTH-1:0] d;
    logic [RD_LAT-1:0][DATA_WIDTH-1:0] t;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v <= '0;
            e <= '0;
            d <= '0;
            t <= '0;
        end else begin
            v[0] <= in_valid;
            e[0] <= in_err;
            if (in_valid) begin
                d[0] <= in_data;
                t[0] <= in_taint;
            end
            for (int i = RD_LAT - 1; i > 0; i--) begin
                v[i] <= v[i-1];
                e[i] <= e[i-1];
                if (v[i-1]) begin
                    d[i] <= d[i-1];
                    t[i] <= t[i-1];
                end
            end
        end
    end

    assign out_valid = v[RD_LAT-1];
    assign out_err   = e[RD_LAT-1];
    assign out_data  = d[RD_LAT-1];
    assign out_taint = t[RD_LAT-1];

endmodule

// File: rtl/ift_sram_mp.sv
// Multi-port byte-enabled SRAM with shadow taint and reset-time taint scrub.
// Define SRAM_ADDR_TAINT_EN to propagate address/control taint.
module ift_sram_mp
    import ift_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_BYTES  = DATA_WIDTH / 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_PORTS  = 2,
    parameter int RD_LAT     = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_PORTS-1:0]                 req_i,
    input  logic [NUM_PORTS-1:0]                 req_i_t0,
    input  logic [NUM_PORTS-1:0]                 we_i,
    input  logic [NUM_PORTS-1:0]                 we_i_t0,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i_t0,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i_t0,
    input  logic [NUM_PORTS-1:0][NUM_BYTES-1:0]  be_i,
    input  logic [NUM_PORTS-1:0][NUM_BYTES-1:0]  be_i_t0,
    output logic [NUM_PORTS-1:0]                 gnt_o,
    output logic [NUM_PORTS-1:0]                 rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o_t0,
    output logic [NUM_PORTS-1:0]                 err_o,
    output logic                                 init_done_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    state_e          state;
    logic [IW-1:0]   scrub_idx;
    logic            init_done;

    logic [DATA_WIDTH-1:0] mem    [DEPTH];
    logic [DATA_WIDTH-1:0] mem_t0 [DEPTH];

    logic [NUM_PORTS-1:0]  in_range;
    logic [NUM_PORTS-1:0]  rd_en;
    logic [NUM_PORTS-1:0]  wr_en;
    logic [NUM_PORTS-1:0]  wr_err_q;
    logic [NUM_PORTS-1:0]  pipe_err;
    logic [IW-1:0]         idx      [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wmask    [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wtaint   [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rd_data  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rd_taint [NUM_PORTS];

    logic unused_t0;
    assign unused_t0 = ^{req_i_t0, we_i_t0, addr_i_t0, be_i_t0};

    assign gnt_o       = (state == ST_READY) ? req_i : '0;
    assign init_done_o = init_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_INIT;
            scrub_idx <= '0;
            init_done <= 1'b0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    if (scrub_idx == IW'(DEPTH - 1)) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end else begin
                        scrub_idx <= scrub_idx + 1'b1;
                    end
                end
                ST_READY: init_done <= 1'b1;
                default:  state     <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin : g_dec
            logic                  ctl_t;
            logic [DATA_WIDTH-1:0] addr_t;
`ifdef SRAM_ADDR_TAINT_EN
            ctl_t  = (|addr_i_t0[p]) | (|be_i_t0[p]) | we_i_t0[p];
            addr_t = {DATA_WIDTH{|addr_i_t0[p]}};
`else
            ctl_t  = 1'b0;
            addr_t = '0;
`endif
            in_range[p] = addr_i[p] < DEPTH_A;
            idx[p]      = addr_i[p][IW-1:0];
            rd_en[p]    = gnt_o[p] & ~we_i[p];
            wr_en[p]    = gnt_o[p] & we_i[p] & in_range[p];
            wmask[p]    = DATA_WIDTH'(be_to_mask(MAX_BYTES'(be_i[p])));
            // tainted control poisons every byte it is allowed to write
            wtaint[p]   = wdata_i_t0[p] | ({DATA_WIDTH{ctl_t}} & wmask[p]);
            rd_data[p]  = in_range[p] ? mem[idx[p]] : '0;
            rd_taint[p] = in_range[p] ? (mem_t0[idx[p]] | addr_t) : '0;
        end
    end

    // Highest port first so the lowest-index port's byte lands last and wins
    always_ff @(posedge clk_i) begin
        if (state == ST_INIT) begin
            mem_t0[scrub_idx] <= '0;
        end
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (wr_en[p]) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (wmask[p][8*b]) begin
                        mem[idx[p]][8*b +: 8]    <= wdata_i[p][8*b +: 8];
                        mem_t0[idx[p]][8*b +: 8] <= wtaint[p][8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_err_q <= '0;
        end else begin
            wr_err_q <= gnt_o & we_i & ~in_range;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        ift_sram_rd_pipe #(
            .DATA_WIDTH(DATA_WIDTH),
            .RD_LAT    (RD_LAT)
        ) u_pipe (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .in_valid (rd_en[p]),
            .in_err   (rd_en[p] & ~in_range[p]),
            .in_data  (rd_data[p]),
            .in_taint (rd_taint[p]),
            .out_valid(rvalid_o[p]),
            .out_err  (pipe_err[p]),
            .out_data (rdata_o[p]),
            .out_taint(rdata_o_t0[p])
        );
    end

    assign err_o = pipe_err | wr_err_q;

endmodule

// File: tb/tb_ift_sram_mp.sv
// Scoreboard bench for ift_sram_mp: random and directed traffic on two ports.
// Reference model is a plain word/taint array with per-byte priority writes.
module tb_ift_sram_mp;

    localparam int DW    = 64;
    localparam int NB    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 16;
    localparam int NP    = 2;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_ni;
    logic [NP-1:0]          req_i, req_i_t0, we_i, we_i_t0;
    logic [NP-1:0][AW-1:0]  addr_i, addr_i_t0;
    logic [NP-1:0][DW-1:0]  wdata_i, wdata_i_t0;
    logic [NP-1:0][NB-1:0]  be_i, be_i_t0;
    logic [NP-1:0]          gnt_o, rvalid_o, err_o;
    logic [NP-1:0][DW-1:0]  rdata_o, rdata_o_t0;
    logic                   init_done_o;

    ift_sram_mp #(
        .DATA_WIDTH(DW),
        .NUM_BYTES (NB),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .NUM_PORTS (NP),
        .RD_LAT    (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .req_i_t0   (req_i_t0),
        .we_i       (we_i),
        .we_i_t0    (we_i_t0),
        .addr_i     (addr_i),
        .addr_i_t0  (addr_i_t0),
        .wdata_i    (wdata_i),
        .wdata_i_t0 (wdata_i_t0),
        .be_i       (be_i),
        .be_i_t0    (be_i_t0),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .rdata_o_t0 (rdata_o_t0),
        .err_o      (err_o),
        .init_done_o(init_done_o)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [DW-1:0] t;
        bit            e;
        int            c;
    } exp_t;

    exp_t          q0[$], q1[$];
    int            wq0[$], wq1[$];
    logic [DW-1:0] ref_d [DEPTH];
    logic [DW-1:0] ref_t [DEPTH];
    logic [DW-1:0] last_d [NP];
    logic [DW-1:0] last_t [NP];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_rd(input int p, input exp_t e);
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_rd(input int p, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{d: '0, t: '0, e: 1'b0, c: 0};
        if (p == 0 && q0.size() > 0) begin
            e = q0.pop_front(); ok = 1'b1;
        end else if (p == 1 && q1.size() > 0) begin
            e = q1.pop_front(); ok = 1'b1;
        end
    endtask

    task automatic wr_due(input int p, output bit due);
        due = 1'b0;
        if (p == 0 && wq0.size() > 0 && wq0[0] == cyc) begin
            void'(wq0.pop_front()); due = 1'b1;
        end else if (p == 1 && wq1.size() > 0 && wq1[0] == cyc) begin
            void'(wq1.pop_front()); due = 1'b1;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a result
    always @(negedge clk) begin
        if (rst_ni) begin
            for (int p = 0; p < NP; p++) begin
                exp_t e;
                bit   ok;
                bit   wdue;
                bit   rerr;
                rerr = 1'b0;
                wr_due(p, wdue);
                if (rvalid_o[p]) begin
                    pop_rd(p, e, ok);
                    if (!ok) begin
                        checks++;
                        errors++;
                        $display("FAIL p%0d spurious rvalid: got 1 expected 0", p);
                    end else begin
                        chk($sformatf("p%0d rdata", p), rdata_o[p], e.d);
                        chk($sformatf("p%0d rdata_t0", p), rdata_o_t0[p], e.t);
                        chk($sformatf("p%0d rvalid cycle", p), DW'(cyc), DW'(e.c));
                        rerr      = e.e;
                        last_d[p] = e.d;
                        last_t[p] = e.t;
                    end
                end else begin
                    chk($sformatf("p%0d rdata hold", p), rdata_o[p], last_d[p]);
                    chk($sformatf("p%0d taint hold", p), rdata_o_t0[p], last_t[p]);
                end
                if (rvalid_o[p] || err_o[p] || wdue)
                    chk($sformatf("p%0d err", p), DW'(err_o[p]), DW'(rerr | wdue));
            end
        end
    end

    // One request cycle on both ports; model updated from the rules directly
    task automatic do_cycle(input logic [NP-1:0] req, input logic [NP-1:0] we,
                            input logic [NP-1:0][AW-1:0] addr,
                            input logic [NP-1:0][AW-1:0] at,
                            input logic [NP-1:0][DW-1:0] wd,
                            input logic [NP-1:0][DW-1:0] wt,
                            input logic [NP-1:0][NB-1:0] be);
        int c;
        c = cyc;
        for (int p = 0; p < NP; p++) begin
            exp_t e;
            if (req[p] && !we[p]) begin
                if (addr[p] < AW'(DEPTH)) begin
                    e.d = ref_d[addr[p][4:0]];
                    e.t = ref_t[addr[p][4:0]];
`ifdef SRAM_ADDR_TAINT_EN
                    if (|at[p]) e.t = '1;
`endif
                    e.e = 1'b0;
                end else begin
                    e.d = '0;
                    e.t = '0;
                    e.e = 1'b1;
                end
                e.c = c + LAT;
                push_rd(p, e);
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (req[p] && we[p]) begin
                if (addr[p] >= AW'(DEPTH)) begin
                    if (p == 0) wq0.push_back(c + 1);
                    else        wq1.push_back(c + 1);
                end else begin
                    for (int b = 0; b < NB; b++) begin
                        bit taken;
                        taken = 1'b0;
                        for (int q = 0; q < p; q++)
                            if (req[q] && we[q] && addr[q] == addr[p] && be[q][b])
                                taken = 1'b1;
                        if (be[p][b] && !taken) begin
                            ref_d[addr[p][4:0]][8*b +: 8] = wd[p][8*b +: 8];
                            ref_t[addr[p][4:0]][8*b +: 8] = wt[p][8*b +: 8];
`ifdef SRAM_ADDR_TAINT_EN
                            if (|at[p]) ref_t[addr[p][4:0]][8*b +: 8] = 8'hFF;
`endif
                        end
                    end
                end
            end
        end
        req_i      = req;
        we_i       = we;
        addr_i     = addr;
        addr_i_t0  = at;
        wdata_i    = wd;
        wdata_i_t0 = wt;
        be_i       = be;
        #1;
        chk("gnt", DW'(gnt_o), DW'(req));
        @(posedge clk);
        #1;
        req_i     = '0;
        we_i      = '0;
        addr_i_t0 = '0;
    endtask

    task automatic wr1(input int p, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] t,
                       input logic [NB-1:0] be);
        logic [NP-1:0]         rq, w;
        logic [NP-1:0][AW-1:0] ad, at;
        logic [NP-1:0][DW-1:0] wd, wt;
        logic [NP-1:0][NB-1:0] bb;
        rq = '0; w = '0; ad = '0; at = '0; wd = '0; wt = '0; bb = '0;
        rq[p] = 1'b1; w[p] = 1'b1; ad[p] = a; wd[p] = d; wt[p] = t; bb[p] = be;
        do_cycle(rq, w, ad, at, wd, wt, bb);
    endtask

    task automatic rd1(input int p, input logic [AW-1:0] a,
                       input logic [AW-1:0] ataint);
        logic [NP-1:0]         rq;
        logic [NP-1:0][AW-1:0] ad, at;
        rq = '0; ad = '0; at = '0;
        rq[p] = 1'b1; ad[p] = a; at[p] = ataint;
        do_cycle(rq, '0, ad, at, '0, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_init();
        int n;
        bit gbad;
        n = 0;
        gbad = 1'b0;
        req_i = '1;
        while (!init_done_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!init_done_o && gnt_o != '0) gbad = 1'b1;
        end
        req_i = '0;
        chk("init cycles", DW'(n), DW'(DEPTH));
        chk("gnt during init", DW'(gbad), '0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NP-1:0]         rq, w;
        logic [NP-1:0][AW-1:0] ad, at;
        logic [NP-1:0][DW-1:0] wd, wt;
        logic [NP-1:0][NB-1:0] bb;
        rst_ni = 1'b0;
        req_i = '0; req_i_t0 = '0; we_i = '0; we_i_t0 = '0;
        addr_i = '0; addr_i_t0 = '0; wdata_i = '0; wdata_i_t0 = '0;
        be_i = '0; be_i_t0 = '0;
        for (int p = 0; p < NP; p++) begin
            last_d[p] = '0;
            last_t[p] = '0;
        end
        req_i = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset gnt", DW'(gnt_o), '0);
        chk("reset rvalid", DW'(rvalid_o), '0);
        chk("reset err", DW'(err_o), '0);
        chk("reset init_done", DW'(init_done_o), '0);
        chk("reset rdata0", rdata_o[0], '0);
        chk("reset rdata1_t0", rdata_o_t0[1], '0);
        req_i = '0;
        @(negedge clk);
        rst_ni = 1'b1;
        wait_init();

        at = '0;
        for (int a = 0; a < DEPTH / 2; a++) begin
            ad[0] = AW'(a); ad[1] = AW'(a + DEPTH / 2);
            wd[0] = {$urandom, $urandom}; wd[1] = {$urandom, $urandom};
            wt[0] = {$urandom, $urandom}; wt[1] = {$urandom, $urandom};
            do_cycle(2'b11, 2'b11, ad, at, wd, wt, {8'hFF, 8'hFF});
        end

        wr1(0, 16'd5, 64'hDEADBEEF_CAFEF00D, 64'h0000_0000_0000_00FF, 8'hFF);
        rd1(0, 16'd5, '0);
        idle(3);

        ad[0] = 16'd3; ad[1] = 16'd3;
        wd[0] = 64'h1111_2222_3333_4444; wd[1] = 64'hAAAA_BBBB_CCCC_DDDD;
        wt[0] = 64'h0000_0000_F0F0_F0F0; wt[1] = 64'h0F0F_0F0F_0F0F_0F0F;
        do_cycle(2'b11, 2'b11, ad, at, wd, wt, {8'hFF, 8'h0F});
        rd1(1, 16'd3, '0);

        ad[0] = 16'd7; ad[1] = 16'd7;
        wd[0] = '0; wd[1] = 64'h7777_0000_7777_0000;
        wt[0] = '0; wt[1] = 64'h0000_0000_0000_FFFF;
        do_cycle(2'b11, 2'b10, ad, at, wd, wt, {8'hFF, 8'h00});
        rd1(0, 16'd7, '0);

        rd1(0, 16'd40, '0);
        wr1(1, 16'd40, 64'h4040_4040_4040_4040, '1, 8'hFF);
        rd1(0, 16'd8, '0);
        rd1(1, 16'd40, '0);

        rd1(0, 16'd9, 16'h0001);
        wr1(0, 16'd10, 64'hBAD0_BAD0_BAD0_BAD0, '1, 8'h00);
        rd1(1, 16'd10, '0);

        for (int i = 0; i < 8; i++) begin
            ad[0] = AW'(i); ad[1] = AW'(DEPTH - 1 - i);
            do_cycle(2'b11, 2'b00, ad, at, '0, '0, '0);
        end
        idle(3);

        for (int i = 0; i < 400; i++) begin
            rq = 2'($urandom_range(0, 3));
            w  = 2'($urandom_range(0, 3));
            for (int p = 0; p < NP; p++) begin
                ad[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 40))
                                                    : AW'($urandom_range(0, 5));
                wd[p] = {$urandom, $urandom};
                wt[p] = {$urandom, $urandom};
                bb[p] = 8'($urandom_range(0, 255));
            end
            do_cycle(rq, w, ad, at, wd, wt, bb);
        end
        idle(LAT + 2);

        rd1(0, 16'd2, '0);
        rst_ni = 1'b0;
        q0.delete(); q1.delete(); wq0.delete(); wq1.delete();
        for (int p = 0; p < NP; p++) begin
            last_d[p] = '0;
            last_t[p] = '0;
        end
        for (int a = 0; a < DEPTH; a++) ref_t[a] = '0;
        #1;
        chk("rvalid killed by reset", DW'(rvalid_o), '0);
        @(negedge clk);
        rst_ni = 1'b1;
        wait_init();
        rd1(0, 16'd2, '0);
        rd1(1, 16'd5, '0);
        idle(LAT + 3);

        chk("q0 drained", DW'(q0.size()), '0);
        chk("q1 drained", DW'(q1.size()), '0);
        chk("wq0 drained", DW'(wq0.size()), '0);
        chk("wq1 drained", DW'(wq1.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ift_sram_mp.md
Name: ift_sram_mp

Overview:
- Multi-port, byte-enabled behavioural SRAM for formal/IFT runs of the core's memory subsystem; successor to the single-port ordered SRAM model.
- Adds per-port request/grant, configurable read latency, deterministic write-conflict arbitration and a reset-time taint-scrub FSM.
- Each data bit has a shadow taint bit (_t0); read data carries stored taint plus optional address-taint propagation.

Parameters:
- DATA_WIDTH, 64, word width in bits; multiple of 8
- NUM_BYTES, DATA_WIDTH/8, byte-enable width
- DEPTH, 32, words implemented; addresses >= DEPTH are out of range
- ADDR_WIDTH, 16, address port width
- NUM_PORTS, 2, independent read/write ports (1..4)
- RD_LAT, 1, read latency in cycles (1..3)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i / req_i_t0  in  NUM_PORTS  per-port request / taint
- we_i / we_i_t0  in  NUM_PORTS  1=write, 0=read / taint
- addr_i / addr_i_t0  in  NUM_PORTS x ADDR_WIDTH  word address / taint
- wdata_i / wdata_i_t0  in  NUM_PORTS x DATA_WIDTH  write data / taint
- be_i / be_i_t0  in  NUM_PORTS x NUM_BYTES  byte enables / taint
- gnt_o  out  NUM_PORTS  request accepted this cycle
- rvalid_o  out  NUM_PORTS  read data valid
- rdata_o / rdata_o_t0  out  NUM_PORTS x DATA_WIDTH  read data / taint
- err_o  out  NUM_PORTS  pulses with rvalid_o (reads) or one cycle after gnt (writes) on out-of-range access
- init_done_o  out  1  taint scrub complete

Behaviour:
- FSM states: INIT, READY. rst_ni low (async) -> INIT, scrub index 0, read pipeline flushed.
- INIT: one shadow word per cycle cleared to 0; after DEPTH-1 -> READY. gnt_o = 0, init_done_o = 0.
- READY: init_done_o = 1; gnt_o[p] = req_i[p] combinationally; stays READY until reset.
- Reset values: gnt_o, rvalid_o, err_o, init_done_o = 0; rdata_o, rdata_o_t0 = 0. Data array not reset (unconstrained for formal).
- Write (granted, we_i=1, in range): bytes with be_i set take wdata_i and wdata_i_t0 at the clock edge. be_i = 0 is a legal no-op.
- Read (granted, we_i=0): rvalid_o[p] asserts exactly RD_LAT cycles after grant. rdata_o holds the word sampled at the grant edge (read-first: same-cycle write to same address is not visible). Between valids, rdata_o/rdata_o_t0 hold the last value.
- Back-to-back reads every cycle sustain full throughput, one result per cycle, in order.
- Write conflict: several ports write the same word in one cycle -> per byte, lowest-index port with that byte enabled wins, for data and taint alike.
- Out of range: write dropped; read returns data 0, taint 0; err_o pulses.
- Async reset during an in-flight read kills the pending rvalid_o; array contents persist.

Optional Feature:
- Macro SRAM_ADDR_TAINT_EN.
- Defined: rdata_o_t0 = stored taint OR {DATA_WIDTH{|addr_t0 captured at grant}}; a write with any tainted addr/be/we bit writes all-ones taint into enabled bytes.
- Undefined: rdata_o_t0 = stored taint only; control-signal taint ignored.

Decomposition:
- Package ift_sram_pkg: state enum (INIT, READY), max NUM_PORTS / RD_LAT constants, function expanding be to a bit mask.
- Sub-module ift_sram_rd_pipe: RD_LAT-deep shift register of {valid, err, data, taint} per port, flushed by async reset.

Test Plan:
- Reset, then poll -> init_done_o rises after DEPTH (32) cycles; gnt_o = 0 throughout INIT.
- Port0 writes addr 5 = 0xDEADBEEF_CAFEF00D, be=0xFF, taint 0x00FF; read addr 5 with RD_LAT=2 -> rvalid_o 2 cycles after grant, rdata_o = written value, rdata_o_t0 = 0x00FF.
- Port0 and port1 write addr 3 same cycle, be 0x0F / 0xFF -> low 4 bytes from port0, high 4 from port1.
- Read addr 7 while port1 writes addr 7 same cycle -> old data returned; next read shows new data.
- Read addr 40 (DEPTH=32) -> rdata_o = 0, err_o = 1 with rvalid_o; write addr 40 leaves array unchanged.
- SRAM_ADDR_TAINT_EN defined, read with addr_i_t0 = 0x1 -> rdata_o_t0 all ones; undefined -> stored taint only.
